// File: rtl/mesi_isc_pkg.sv
// Shared coherence-bus agent types: command codes, MESI line states and agent FSM states.
package mesi_isc_pkg;

    typedef enum logic [2:0] {
        CMD_NOP      = 3'd0,
        CMD_WR_SNOOP = 3'd1,
        CMD_RD_SNOOP = 3'd2,
        CMD_EN_WR    = 3'd3,
        CMD_EN_RD    = 3'd4
    } cbus_cmd_e;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOOKUP   = 3'd1,
        ST_WB       = 3'd2,
        ST_CORE     = 3'd3,
        ST_ACK      = 3'd4,
        ST_WAIT_NOP = 3'd5
    } agent_st_e;

endpackage

// File: rtl/mesi_isc_cbus_agent_tbl.sv
// Direct-mapped line-state table: one combinational lookup port, one registered update port.
module mesi_isc_cbus_agent_tbl
    import mesi_isc_pkg::*;
#(
    parameter int LINE_IDX_WIDTH = 3,
    parameter int TAG_WIDTH      = 29
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LINE_IDX_WIDTH-1:0] lk_idx,
    input  logic [TAG_WIDTH-1:0]      lk_tag,
    output logic                      lk_hit,
    output mesi_e                     lk_state,
    input  logic                      upd_en,
    input  logic [LINE_IDX_WIDTH-1:0] upd_idx,
    input  logic [TAG_WIDTH-1:0]      upd_tag,
    input  mesi_e                     upd_state
);

    localparam int DEPTH = 1 << LINE_IDX_WIDTH;

    logic [TAG_WIDTH-1:0] tag_q   [DEPTH];
    mesi_e                state_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= MESI_I;
            end
        end else if (upd_en) begin
            state_q[upd_idx] <= upd_state;
        end
    end

    // Tags need no reset: an I line never hits regardless of its tag.
    always_ff @(posedge clk) begin
        if (rst && upd_en) begin
            tag_q[upd_idx] <= upd_tag;
        end
    end

    assign lk_state = state_q[lk_idx];
    assign lk_hit   = (tag_q[lk_idx] == lk_tag) && (lk_state != MESI_I);

endmodule

// File: rtl/mesi_isc_cbus_agent.sv
// Per-CPU coherence-bus agent: serves snoops and core grants from the broadcast controller.
module mesi_isc_cbus_agent
    import mesi_isc_pkg::*;
#(
    parameter int CBUS_CMD_WIDTH = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_IDX_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
    input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
    output logic                      cbus_ack_o,
    output logic                      core_en_wr_o,
    output logic                      core_en_rd_o,
    input  logic                      core_done_i,
    output logic                      wb_req_o,
    output logic [ADDR_WIDTH-1:0]     wb_addr_o,
    input  logic                      wb_ready_i
);

    localparam int CW    = CBUS_CMD_WIDTH;
    localparam int TAG_W = ADDR_WIDTH - LINE_IDX_WIDTH;

    agent_st_e               state_q;
    agent_st_e               state_d;
    logic [CW-1:0]           cmd_q;
    logic [ADDR_WIDTH-1:0]   addr_q;

    logic  cmd_legal;
    logic  is_wr_snp;
    logic  is_rd_snp;
    logic  is_en_wr;
    logic  is_en_rd;
    logic  lk_hit;
    mesi_e lk_state;
    logic  upd_en;
    mesi_e upd_state;

    assign cmd_legal = (cbus_cmd_i >= CW'(CMD_WR_SNOOP))
                    && (cbus_cmd_i <= CW'(CMD_EN_RD));

    assign is_wr_snp = (cmd_q == CW'(CMD_WR_SNOOP));
    assign is_rd_snp = (cmd_q == CW'(CMD_RD_SNOOP));
    assign is_en_wr  = (cmd_q == CW'(CMD_EN_WR));
    assign is_en_rd  = (cmd_q == CW'(CMD_EN_RD));

    mesi_isc_cbus_agent_tbl #(
        .LINE_IDX_WIDTH (LINE_IDX_WIDTH),
        .TAG_WIDTH      (TAG_W)
    ) u_tbl (
        .clk       (clk),
        .rst       (rst),
        .lk_idx    (addr_q[LINE_IDX_WIDTH-1:0]),
        .lk_tag    (addr_q[ADDR_WIDTH-1:LINE_IDX_WIDTH]),
        .lk_hit    (lk_hit),
        .lk_state  (lk_state),
        .upd_en    (upd_en),
        .upd_idx   (addr_q[LINE_IDX_WIDTH-1:0]),
        .upd_tag   (addr_q[ADDR_WIDTH-1:LINE_IDX_WIDTH]),
        .upd_state (upd_state)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && cmd_legal) begin
                cmd_q  <= cbus_cmd_i;
                addr_q <= cbus_addr_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_legal) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (is_en_wr || is_en_rd)
                    state_d = ST_CORE;
                else if (lk_hit && lk_state == MESI_M)
                    state_d = ST_WB;
                else
                    state_d = ST_ACK;
            end
            ST_WB: begin
                if (wb_ready_i) state_d = ST_ACK;
            end
            ST_CORE: begin
                if (core_done_i) state_d = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_WAIT_NOP;
            end
            ST_WAIT_NOP: begin
                if (cbus_cmd_i == CW'(CMD_NOP)) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The lookup port still reflects the pre-update line while in ACK.
    always_comb begin
        upd_en    = 1'b0;
        upd_state = lk_state;
        unique case (1'b1)
            is_wr_snp && lk_hit: begin
                upd_en    = 1'b1;
                upd_state = MESI_I;
            end
            is_rd_snp && lk_hit
                && (lk_state == MESI_M || lk_state == MESI_E): begin
                upd_en    = 1'b1;
                upd_state = MESI_S;
            end
            is_en_wr: begin
                upd_en    = 1'b1;
                upd_state = MESI_M;
            end
            is_en_rd: begin
                upd_en    = 1'b1;
                upd_state = MESI_S;
            end
            default: begin
                upd_en    = 1'b0;
            end
        endcase
        if (state_q != ST_ACK) upd_en = 1'b0;
    end

    assign cbus_ack_o   = (state_q == ST_ACK);
    assign wb_req_o     = (state_q == ST_WB);
    assign wb_addr_o    = wb_req_o ? addr_q : '0;
    assign core_en_wr_o = (state_q == ST_CORE) && is_en_wr;
    assign core_en_rd_o = (state_q == ST_CORE) && is_en_rd;

endmodule

// File: tb/tb_mesi_isc_cbus_agent.sv
// Scoreboard bench for the coherence-bus agent against a small MESI table model.
module tb_mesi_isc_cbus_agent;
    import mesi_isc_pkg::*;

    logic        clk;
    logic        rst;
    logic [2:0]  cbus_cmd_i;
    logic [31:0] cbus_addr_i;
    logic        cbus_ack_o;
    logic        core_en_wr_o;
    logic        core_en_rd_o;
    logic        core_done_i;
    logic        wb_req_o;
    logic [31:0] wb_addr_o;
    logic        wb_ready_i;

    mesi_isc_cbus_agent #(
        .CBUS_CMD_WIDTH (3),
        .ADDR_WIDTH     (32),
        .LINE_IDX_WIDTH (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cbus_cmd_i   (cbus_cmd_i),
        .cbus_addr_i  (cbus_addr_i),
        .cbus_ack_o   (cbus_ack_o),
        .core_en_wr_o (core_en_wr_o),
        .core_en_rd_o (core_en_rd_o),
        .core_done_i  (core_done_i),
        .wb_req_o     (wb_req_o),
        .wb_addr_o    (wb_addr_o),
        .wb_ready_i   (wb_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        int          wb_cyc;
        logic [31:0] wb_addr;
        int          wr_cyc;
        int          rd_cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [28:0] mtag [8];
    logic [1:0]  mst  [8];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lines_i(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk(tag, 64'(dut.u_tbl.state_q[i]), 64'(MESI_I));
        end
    endtask

    task automatic do_cmd(input logic [2:0] c, input logic [31:0] a,
                          input int hold, input int extra,
                          input bit scramble);
        exp_t        e;
        exp_t        got;
        int          idx;
        logic [28:0] tg;
        logic        hit;
        logic        wb;
        logic [1:0]  nst;
        bit          seen;
        int          quiet;
        idx = int'(a[2:0]);
        tg  = a[31:3];
        hit = (mtag[idx] == tg) && (mst[idx] != 2'(MESI_I));
        wb  = (c == CMD_WR_SNOOP || c == CMD_RD_SNOOP)
              && hit && mst[idx] == 2'(MESI_M);
        nst = mst[idx];
        case (c)
            CMD_WR_SNOOP: if (hit) nst = 2'(MESI_I);
            CMD_RD_SNOOP: if (hit && (mst[idx] == 2'(MESI_M)
                              || mst[idx] == 2'(MESI_E))) nst = 2'(MESI_S);
            CMD_EN_WR:    nst = 2'(MESI_M);
            CMD_EN_RD:    nst = 2'(MESI_S);
            default:      nst = mst[idx];
        endcase
        e.lat     = (wb || c == CMD_EN_WR || c == CMD_EN_RD) ? 2 + hold : 2;
        e.wb_cyc  = wb ? hold : 0;
        e.wb_addr = wb ? a : 32'h0;
        e.wr_cyc  = (c == CMD_EN_WR) ? hold : 0;
        e.rd_cyc  = (c == CMD_EN_RD) ? hold : 0;
        sb.push_back(e);

        cbus_cmd_i  = c;
        cbus_addr_i = a;
        got.lat = 0; got.wb_cyc = 0; got.wb_addr = 0;
        got.wr_cyc = 0; got.rd_cyc = 0;
        seen = 0;
        while (!seen && got.lat < 60) begin
            @(posedge clk); #1;
            got.lat++;
            core_done_i = 1'b0;
            wb_ready_i  = 1'b0;
            if (wb_req_o) begin
                if (got.wb_cyc == 0) got.wb_addr = wb_addr_o;
                got.wb_cyc++;
                if (got.wb_cyc == hold) wb_ready_i = 1'b1;
            end
            if (core_en_wr_o) got.wr_cyc++;
            if (core_en_rd_o) got.rd_cyc++;
            if ((core_en_wr_o || core_en_rd_o)
                && got.wr_cyc + got.rd_cyc == hold) core_done_i = 1'b1;
            if (scramble && (wb_req_o || core_en_wr_o || core_en_rd_o)) begin
                cbus_cmd_i  = CMD_WR_SNOOP;
                cbus_addr_i = a ^ 32'h8;
            end
            if (cbus_ack_o) seen = 1;
        end
        core_done_i = 1'b0;
        wb_ready_i  = 1'b0;
        chk("ack_seen", 64'(seen), 64'd1);
        e = sb.pop_front();
        chk("ack_lat", 64'(got.lat), 64'(e.lat));
        chk("wb_cyc", 64'(got.wb_cyc), 64'(e.wb_cyc));
        chk("wb_addr", 64'(got.wb_addr), 64'(e.wb_addr));
        chk("wr_cyc", 64'(got.wr_cyc), 64'(e.wr_cyc));
        chk("rd_cyc", 64'(got.rd_cyc), 64'(e.rd_cyc));
        mtag[idx] = (c == CMD_EN_WR || c == CMD_EN_RD) ? tg : mtag[idx];
        mst[idx]  = nst;

        quiet = 0;
        for (int k = 0; k < extra; k++) begin
            @(posedge clk); #1;
            if (cbus_ack_o || core_en_wr_o || core_en_rd_o || wb_req_o)
                quiet++;
        end
        chk("no_repeat", 64'(quiet), 64'd0);
        chk("line_st", 64'(dut.u_tbl.state_q[idx]), 64'(mst[idx]));
        cbus_cmd_i = CMD_NOP;
        @(posedge clk); #1;
        chk("idle_after_nop", 64'(dut.state_q), 64'(ST_IDLE));
    endtask

    initial begin
        int budget;
        logic [31:0] pool [4];
        rst         = 1'b0;
        cbus_cmd_i  = CMD_NOP;
        cbus_addr_i = 32'h0;
        core_done_i = 1'b0;
        wb_ready_i  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mtag[i] = '0;
            mst[i]  = 2'(MESI_I);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 64'(cbus_ack_o), 64'd0);
        chk("rst_en_wr", 64'(core_en_wr_o), 64'd0);
        chk("rst_en_rd", 64'(core_en_rd_o), 64'd0);
        chk("rst_wb_req", 64'(wb_req_o), 64'd0);
        chk("rst_wb_addr", 64'(wb_addr_o), 64'd0);
        chk("rst_fsm", 64'(dut.state_q), 64'(ST_IDLE));
        chk_lines_i("rst_line");
        rst = 1'b1;
        @(posedge clk); #1;

        do_cmd(CMD_RD_SNOOP, 32'h100, 1, 1, 0);
        do_cmd(CMD_EN_WR,    32'h40,  3, 1, 1);
        do_cmd(CMD_RD_SNOOP, 32'h40,  2, 1, 0);
        do_cmd(CMD_RD_SNOOP, 32'h40,  1, 1, 0);
        do_cmd(CMD_EN_RD,    32'h80,  1, 1, 0);
        do_cmd(CMD_WR_SNOOP, 32'h80,  1, 1, 0);
        do_cmd(CMD_RD_SNOOP, 32'h80,  1, 1, 0);
        do_cmd(CMD_EN_RD,    32'h88,  2, 4, 0);
        do_cmd(CMD_EN_RD,    32'h90,  1, 1, 0);

        cbus_cmd_i  = 3'd6;
        cbus_addr_i = 32'h40;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("cmd6_ack", 64'(cbus_ack_o), 64'd0);
            chk("cmd6_grant", 64'(core_en_wr_o | core_en_rd_o), 64'd0);
            chk("cmd6_fsm", 64'(dut.state_q), 64'(ST_IDLE));
        end
        cbus_cmd_i = CMD_NOP;
        @(posedge clk); #1;

        pool[0] = 32'h40; pool[1] = 32'h48;
        pool[2] = 32'h80; pool[3] = 32'h13;
        for (int k = 0; k < 24; k++) begin
            do_cmd(3'($urandom_range(4, 1)), pool[$urandom_range(3, 0)],
                   int'($urandom_range(3, 1)), int'($urandom_range(2, 1)), 0);
        end

        do_cmd(CMD_EN_WR, 32'h48, 1, 1, 0);
        cbus_cmd_i  = CMD_RD_SNOOP;
        cbus_addr_i = 32'h48;
        budget = 0;
        while (!wb_req_o && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("wb_reached", 64'(wb_req_o), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midwb_wb_req", 64'(wb_req_o), 64'd0);
        chk("midwb_ack", 64'(cbus_ack_o), 64'd0);
        chk("midwb_fsm", 64'(dut.state_q), 64'(ST_IDLE));
        chk_lines_i("midwb_line");
        rst        = 1'b1;
        cbus_cmd_i = CMD_NOP;
        for (int i = 0; i < 8; i++) mst[i] = 2'(MESI_I);
        @(posedge clk); #1;
        do_cmd(CMD_RD_SNOOP, 32'h48, 1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mesi_isc_cbus_agent.md
MESI_ISC_CBUS_AGENT -- requirements
Module: mesi_isc_cbus_agent

Interface
REQ-001 SHALL have parameters: CBUS_CMD_WIDTH, default 3, coherence-bus command width; ADDR_WIDTH, default 32, address width; LINE_IDX_WIDTH, default 3, log2 of the line-state table depth.
REQ-002 SHALL use one clock and a synchronous, active-low reset: clk and rst.
REQ-003 Port clk, input, 1, system clock.
REQ-004 Port rst, input, 1, synchronous active-low reset.
REQ-005 Port cbus_cmd_i, input, CBUS_CMD_WIDTH, command from the broadcast controller for this CPU.
REQ-006 Port cbus_addr_i, input, ADDR_WIDTH, line address for the command.
REQ-007 Port cbus_ack_o, input-side ack to the controller, output, 1, command completed.
REQ-008 Port core_en_wr_o, output, 1, grant: core performs its pending write.
REQ-009 Port core_en_rd_o, output, 1, grant: core performs its pending read.
REQ-010 Port core_done_i, input, 1, core finished the granted access.
REQ-011 Port wb_req_o, output, 1, write-back request to memory.
REQ-012 Port wb_addr_o, output, ADDR_WIDTH, write-back line address.
REQ-013 Port wb_ready_i, input, 1, memory accepts the write-back this cycle.

Function
REQ-014 SHALL use command encodings NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4; values 5-7 are ignored like NOP.
REQ-015 SHALL hold a table of 2^LINE_IDX_WIDTH entries: tag (addr above the index), MESI state. Index = addr[LINE_IDX_WIDTH-1:0]. Hit = tag match and state != I.
REQ-016 The FSM SHALL have states IDLE, LOOKUP, WB, CORE, ACK, WAIT_NOP.
REQ-017 IDLE: on a legal non-NOP cmd, register cmd and addr, then go to LOOKUP. Otherwise stay in IDLE.
REQ-018 LOOKUP, snoop command: a hit in M goes to WB; any other case goes to ACK. EN_WR or EN_RD goes to CORE.
REQ-019 WB: wb_req_o=1, wb_addr_o=registered addr. On wb_ready_i=1 in the same cycle, go to ACK.
REQ-020 CORE: core_en_wr_o (EN_WR) or core_en_rd_o (EN_RD) is held at 1. On core_done_i=1, go to ACK.
REQ-021 ACK: cbus_ack_o=1 for exactly one cycle, and the table is updated in that same cycle, then go to WAIT_NOP.
 - WR_SNOOP hit: state becomes I.
 - RD_SNOOP hit in M or E: state becomes S.
 - EN_WR: tag written, state becomes M.
 - EN_RD: tag written, state becomes S.
 - Snoop miss: no change.
REQ-022 WAIT_NOP: stay until cbus_cmd_i==NOP, then go to IDLE. A repeated command is never processed twice.
REQ-023 Latency from cmd first visible in IDLE to cbus_ack_o:
 - snoop with no write-back: 2 cycles;
 - M write-back: 2 + WB stall cycles + 1;
 - EN_*: 2 + CORE stall cycles + 1.
REQ-024 All outputs SHALL be registered or decoded from the FSM state only, with no combinational path from any input.
REQ-025 A cbus_cmd_i change while the FSM is outside IDLE and WAIT_NOP SHALL be ignored; the registered cmd and addr govern completion.

Reset
REQ-026 With rst=0 at a clk edge, the FSM SHALL return to IDLE from any state, including mid-WB and mid-CORE.
REQ-027 During reset, all table states SHALL be set to I.
REQ-028 During reset, cbus_ack_o, core_en_wr_o, core_en_rd_o and wb_req_o SHALL be 0, and wb_addr_o SHALL be 0.

Structure
REQ-029 Command encodings, MESI state enum and FSM state enum SHALL live in the shared mesi_isc package and defines.
REQ-030 The line table SHALL be one sub-module, mesi_isc_cbus_agent_tbl, with one lookup port and one update port.

Verification
REQ-031 Reset, then RD_SNOOP to an address not in the table -> cbus_ack_o=1 exactly 2 cycles later; no wb_req_o; state unchanged.
REQ-032 EN_WR at 0x40, core_done_i after 3 cycles -> core_en_wr_o high 3 cycles, then ack; later RD_SNOOP 0x40 -> wb_req_o with wb_addr_o=0x40, then ack after wb_ready_i, line becomes S.
REQ-033 EN_RD at 0x80, then WR_SNOOP 0x80 -> no write-back, ack at 2 cycles, line becomes I; a following RD_SNOOP 0x80 is a miss.
REQ-034 cmd held for 4 cycles after ack -> exactly one cbus_ack_o pulse; new EN_RD is accepted only after NOP is seen.
REQ-035 rst=0 asserted while in WB with wb_ready_i=0 -> next cycle wb_req_o=0, FSM in IDLE, all lines I.
REQ-036 cmd=6 in IDLE -> no ack, no grant, FSM stays IDLE.
